shared_debounce_arbiter: RTL

Four push-buttons share one debounce counter through a round-robin arbiter instead of each button having its own counter.
- The granted button is qualified for press and for release.
- Each qualified press produces exactly one single-cycle event pulse.
- The pulse drives an 8-bit LED value register: inc, dec, clear, set-all.
- Sits between the raw board buttons and the LED outputs in the lab top level.

---
 rtl/shared_debounce_pkg.sv | 36 +++
 rtl/shared_debounce_arbiter_sync2.sv | 27 ++
 rtl/shared_debounce_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/shared_debounce_pkg.sv
// Shared types, button indices and the round-robin selector for the
// shared debounce arbiter.
package shared_debounce_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CNT = 3'd1,
        FIRE      = 3'd2,
        WAIT_REL  = 3'd3,
        REL_CNT   = 3'd4
    } state_e;

    localparam logic [1:0] BTN_INC = 2'd0;
    localparam logic [1:0] BTN_DEC = 2'd1;
    localparam logic [1:0] BTN_CLR = 2'd2;
    localparam logic [1:0] BTN_SET = 2'd3;

    // First asserted request at or after ptr, searching cyclically.
    // Returns ptr when nothing is requested; callers only use it when |req.
    function automatic logic [1:0] rr_select(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/shared_debounce_arbiter_sync2.sv
// Two-flop synchronizer for the raw, asynchronous board buttons.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back stages; both clear on reset so a held button is re-seen.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/shared_debounce_arbiter.sv
// Four buttons share one debounce counter through a round-robin arbiter.
// A qualified press gives one Pulse cycle and updates the LED register.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// IDLE      | no owner; pick the next held button starting at ptr
// PRESS_CNT | owner held; count stable-high cycles until counter MSB
// FIRE      | single Pulse cycle; LED op applied on the edge leaving it
// WAIT_REL  | owner still held; wait for the first low sample
// REL_CNT   | owner low; count stable-low cycles until counter MSB
module shared_debounce_arbiter #(
    parameter int CNT_W = 18,
    parameter int VAL_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [3:0]       Buttons,
    output logic [3:0]       Pulse,
    output logic [3:0]       Grant,
    output logic             Busy,
    output logic [VAL_W-1:0] LEDs
);
    import shared_debounce_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [VAL_W-1:0] VAL_ONE = VAL_W'(1);

    logic [3:0]       sync;
    logic             btn_sync;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [1:0]       sel_q,   sel_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [VAL_W-1:0] leds_q,  leds_d;

    sync2 #(.WIDTH(4)) u_sync2 (
        .Clk (Clk),
        .Rst (Rst),
        .d_i (Buttons),
        .q_o (sync)
    );

    assign btn_sync = sync[sel_q];

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            count_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            pulse_q <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            leds_q  <= leds_d;
        end
    end

    // Next-state, shared counter, arbitration pointer and LED update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        pulse_d = '0;
        leds_d  = leds_q;

        case (state_q)
            IDLE: begin
                if (|sync) begin
                    sel_d   = rr_select(sync, ptr_q);
                    grant_d = 4'b0001 << sel_d;
                    count_d = '0;
                    state_d = PRESS_CNT;
                end
            end
            PRESS_CNT: begin
                if (!btn_sync) begin
                    // Bounce: give the counter to the next button in line.
                    grant_d = '0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                end else if (!count_q[CNT_W-1]) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    pulse_d = 4'b0001 << sel_q;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                state_d = WAIT_REL;
                case (sel_q)
                    BTN_INC: leds_d = leds_q + VAL_ONE;
                    BTN_DEC: leds_d = leds_q - VAL_ONE;
                    BTN_CLR: leds_d = '0;
                    BTN_SET: leds_d = '1;
                    default: leds_d = leds_q;
                endcase
            end
            WAIT_REL: begin
                if (!btn_sync) begin
                    count_d = '0;
                    state_d = REL_CNT;
                end
            end
            REL_CNT: begin
                if (btn_sync) begin
                    state_d = WAIT_REL;
                end else if (!count_q[CNT_W-1]) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    grant_d = '0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign Pulse = pulse_q;
    assign Grant = grant_q;
    assign Busy  = (state_q != IDLE);
    assign LEDs  = leds_q;

endmodule
